// File: rtl/ps2pl_pkg.sv
// ps2pl_pkg: shared definitions for the PS-to-PL stream routing engine.
//   - SYNC_WORD and header field positions
//   - FSM state encoding
//   - hdr_decode(): splits a header word into {valid, dest, len}
//     ("valid" covers the sync byte and the destination range only;
//      tlast, route_en and length rules are applied by the engine).
package ps2pl_pkg;

    localparam logic [7:0] SYNC_WORD = 8'hA5;

    localparam int SYNC_LSB = 24;
    localparam int SYNC_W   = 8;
    localparam int DEST_LSB = 16;
    localparam int DEST_W   = 8;
    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = 16;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic [LEN_W-1:0]  len;
    } hdr_t;

    function automatic hdr_t hdr_decode(input logic [31:0] word, input int unsigned n_ch);
        hdr_t h;
        h.dest  = word[DEST_LSB +: DEST_W];
        h.len   = word[LEN_LSB +: LEN_W];
        h.valid = (word[SYNC_LSB +: SYNC_W] == SYNC_WORD) && (32'(h.dest) < n_ch);
        return h;
    endfunction

endpackage

// File: rtl/ps2pl_out_reg.sv
// ps2pl_out_reg: single-entry AXI-Stream register slice for one channel.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_data/in_last/in_ready   upstream side (from the engine)
//   m_tdata/m_tlast/m_tvalid/m_tready   downstream AXIS master
// The entry is reloadable in the same cycle it drains, giving one word per
// cycle while m_tready is high.
module ps2pl_out_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready
);
    import ps2pl_pkg::*;

    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic [31:0] data_q, data_d;

    assign in_ready = ~vld_q | m_tready;

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        data_d = data_q;
        if (in_valid && in_ready) begin
            vld_d  = 1'b1;
            last_d = in_last;
            data_d = in_data;
        end else if (m_tready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            data_q <= data_d;
        end
    end

    assign m_tdata  = data_q;
    assign m_tlast  = last_q;
    assign m_tvalid = vld_q;

endmodule

// File: rtl/ps2pl_axis_engine.sv
// ps2pl_axis_engine: receive side of the PS-to-PL DMA path. Parses a one-word
// header (sync A5 / dest / len) and routes the payload to one of N_CH
// AXIS channels through per-channel register slices.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   route_en                    0 = accept and silently discard all packets
//   s_axis_ps2pl_*              input stream from DMA MM2S (tkeep ignored)
//   m_axis_ch_*                 N_CH output streams, channel k at [32k+31:32k]
//   pkt_cnt / err_cnt           saturating delivered / framing-error counters
//   busy                        FSM is mid-packet (not waiting for a header)
// Optional build macro PS2PL_LEN_CHECK_EN: enforces the header length field
// (len=0 rejected, early/late tlast counted as errors). Without it the
// length field is ignored and input tlast alone ends a packet.
module ps2pl_axis_engine #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              route_en,
    input  logic [31:0]       s_axis_ps2pl_tdata,
    input  logic [3:0]        s_axis_ps2pl_tkeep,
    input  logic              s_axis_ps2pl_tlast,
    input  logic              s_axis_ps2pl_tvalid,
    output logic              s_axis_ps2pl_tready,
    output logic [N_CH*32-1:0] m_axis_ch_tdata,
    output logic [N_CH-1:0]   m_axis_ch_tlast,
    output logic [N_CH-1:0]   m_axis_ch_tvalid,
    input  logic [N_CH-1:0]   m_axis_ch_tready,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);
    import ps2pl_pkg::*;

    state_e            state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
`ifdef PS2PL_LEN_CHECK_EN
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
`endif

    hdr_t              hdr;
    logic              s_ready_int;
    logic              pay_valid, pay_last;
    logic              pkt_inc, err_inc;
    logic [N_CH-1:0]   dest_oh, ch_in_ready;
    logic              sel_ready;
    logic              unused_ok;

    assign hdr = hdr_decode(s_axis_ps2pl_tdata, N_CH);

`ifdef PS2PL_LEN_CHECK_EN
    assign unused_ok = ^s_axis_ps2pl_tkeep;
`else
    assign unused_ok = ^{s_axis_ps2pl_tkeep, hdr.len};
`endif

    // Channel select and per-channel output slices
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign dest_oh[gi] = (dest_q == DEST_W'(gi));
            ps2pl_out_reg u_out (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (pay_valid & dest_oh[gi]),
                .in_data  (s_axis_ps2pl_tdata),
                .in_last  (pay_last),
                .in_ready (ch_in_ready[gi]),
                .m_tdata  (m_axis_ch_tdata[32*gi +: 32]),
                .m_tlast  (m_axis_ch_tlast[gi]),
                .m_tvalid (m_axis_ch_tvalid[gi]),
                .m_tready (m_axis_ch_tready[gi])
            );
        end
    endgenerate

    assign sel_ready = |(ch_in_ready & dest_oh);

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        s_ready_int = 1'b0;
        pay_valid   = 1'b0;
        pay_last    = s_axis_ps2pl_tlast;
        pkt_inc     = 1'b0;
        err_inc     = 1'b0;
`ifdef PS2PL_LEN_CHECK_EN
        len_d       = len_q;
        wcnt_d      = wcnt_q;
`endif
        case (state_q)
            S_HDR: begin
                s_ready_int = 1'b1;
                if (s_axis_ps2pl_tvalid) begin
                    if (!route_en) begin
                        // Discard quietly; not a framing error.
                        state_d = s_axis_ps2pl_tlast ? S_HDR : S_DROP;
                    end else if (!hdr.valid || s_axis_ps2pl_tlast
`ifdef PS2PL_LEN_CHECK_EN
                                 || (hdr.len == '0)
`endif
                                 ) begin
                        err_inc = 1'b1;
                        state_d = s_axis_ps2pl_tlast ? S_HDR : S_DROP;
                    end else begin
                        state_d = S_PAY;
                        dest_d  = hdr.dest;
`ifdef PS2PL_LEN_CHECK_EN
                        len_d   = hdr.len;
                        wcnt_d  = '0;
`endif
                    end
                end
            end
            S_PAY: begin
                s_ready_int = sel_ready;
                pay_valid   = s_axis_ps2pl_tvalid;
`ifdef PS2PL_LEN_CHECK_EN
                // Last word by length is forced to carry tlast.
                pay_last = s_axis_ps2pl_tlast || (wcnt_q == len_q - LEN_W'(1));
                if (s_axis_ps2pl_tvalid && sel_ready) begin
                    wcnt_d = wcnt_q + LEN_W'(1);
                    if (wcnt_q == len_q - LEN_W'(1)) begin
                        if (s_axis_ps2pl_tlast) begin
                            pkt_inc = 1'b1;
                            state_d = S_HDR;
                        end else begin
                            err_inc = 1'b1;
                            state_d = S_DROP;
                        end
                    end else if (s_axis_ps2pl_tlast) begin
                        err_inc = 1'b1;
                        state_d = S_HDR;
                    end
                end
`else
                if (s_axis_ps2pl_tvalid && sel_ready && s_axis_ps2pl_tlast) begin
                    pkt_inc = 1'b1;
                    state_d = S_HDR;
                end
`endif
            end
            S_DROP: begin
                s_ready_int = 1'b1;
                if (s_axis_ps2pl_tvalid && s_axis_ps2pl_tlast) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase

        pkt_cnt_d = (pkt_inc && pkt_cnt_q != '1) ? pkt_cnt_q + CNT_W'(1) : pkt_cnt_q;
        err_cnt_d = (err_inc && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_HDR;
            dest_q    <= '0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
`ifdef PS2PL_LEN_CHECK_EN
            len_q     <= '0;
            wcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
`ifdef PS2PL_LEN_CHECK_EN
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    // Not ready while reset is held, whatever the state.
    assign s_axis_ps2pl_tready = rst_n & s_ready_int;
    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
    assign busy    = (state_q != S_HDR);

endmodule

// File: tb/tb_ps2pl_axis_engine.sv
// Self-checking bench for ps2pl_axis_engine: a packet-level model pushes
// expected output beats per channel into queues; a negedge monitor pops and
// compares each beat the DUT hands over.
module tb_ps2pl_axis_engine;
    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              route_en;
    logic [31:0]       s_tdata;
    logic [3:0]        s_tkeep;
    logic              s_tlast;
    logic              s_tvalid;
    logic              s_tready;
    logic [N_CH*32-1:0] m_tdata;
    logic [N_CH-1:0]   m_tlast;
    logic [N_CH-1:0]   m_tvalid;
    logic [N_CH-1:0]   m_tready;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              busy;

    ps2pl_axis_engine #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .route_en            (route_en),
        .s_axis_ps2pl_tdata  (s_tdata),
        .s_axis_ps2pl_tkeep  (s_tkeep),
        .s_axis_ps2pl_tlast  (s_tlast),
        .s_axis_ps2pl_tvalid (s_tvalid),
        .s_axis_ps2pl_tready (s_tready),
        .m_axis_ch_tdata     (m_tdata),
        .m_axis_ch_tlast     (m_tlast),
        .m_axis_ch_tvalid    (m_tvalid),
        .m_axis_ch_tready    (m_tready),
        .pkt_cnt             (pkt_cnt),
        .err_cnt             (err_cnt),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pkt  = 0;
    int exp_err  = 0;
    int stall_cnt = 0;
    logic [32:0] sb [N_CH][$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: a beat transfers at the next posedge when valid&ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < N_CH; k++) begin
                if (m_tvalid[k] && m_tready[k]) begin
                    check_eq($sformatf("ch%0d_expected_beat", k), 64'(sb[k].size() > 0), 64'd1);
                    if (sb[k].size() > 0) begin
                        logic [32:0] e;
                        e = sb[k].pop_front();
                        $display("ch%0d beat data=%08h last=%0d", k, m_tdata[32*k +: 32], m_tlast[k]);
                        check_eq($sformatf("ch%0d_beat", k), {31'd0, m_tlast[k], m_tdata[32*k +: 32]}, 64'(e));
                    end
                end
            end
        end
    end

    // Drive one input beat (called at posedge+1); returns at posedge+1 after handshake.
    task automatic send_beat(input logic [31:0] d, input logic last);
        logic ok;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            if (ok) return;
            stall_cnt++;
        end
        check_eq("s_tready_timeout", 64'(s_tready), 64'd1);
    endtask

    task automatic drain();
        int total;
        total = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            total = 0;
            for (int k = 0; k < N_CH; k++) total += sb[k].size();
            if (total == 0) break;
        end
        check_eq("drain_remaining", 64'(total), 64'd0);
        check_eq("idle_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        check_eq("err_cnt", 64'(err_cnt), 64'(exp_err));
    endtask

    // Full packet: header then n words (base + 0x11*i), tlast on the last beat.
    task automatic send_pkt(input logic [31:0] hdr, input int n, input logic [31:0] base);
        logic [7:0] d;
        int len, n_out;
        bit ok;
        d   = hdr[23:16];
        len = int'(hdr[15:0]);
        ok  = route_en && (hdr[31:24] == 8'hA5) && (d < N_CH) && (n > 0);
`ifdef PS2PL_LEN_CHECK_EN
        ok  = ok && (len != 0);
`endif
        n_out = 0;
        if (route_en && !ok) exp_err++;
        else if (ok) begin
`ifdef PS2PL_LEN_CHECK_EN
            if (n == len) begin n_out = n; exp_pkt++; end
            else if (n < len) begin n_out = n; exp_err++; end
            else begin n_out = len; exp_err++; end
`else
            n_out = n;
            exp_pkt++;
`endif
            for (int i = 0; i < n_out; i++)
                sb[d].push_back({1'(i == n_out - 1), base + 32'h11 * i});
        end
        $display("pkt hdr=%08h words=%0d route_en=%0d expect_out=%0d", hdr, n, route_en, n_out);
        send_beat(hdr, n == 0);
        check_eq("busy_after_hdr", 64'(busy), 64'(n > 0));
        for (int i = 0; i < n; i++) send_beat(base + 32'h11 * i, i == n - 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    initial begin
        bit saw_low;
        rst_n = 1'b0; route_en = 1'b1; s_tdata = '0; s_tkeep = 4'hF;
        s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tready", 64'(s_tready), 64'd0);
        check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_tlast", 64'(m_tlast), 64'd0);
        check_eq("rst_tdata", 64'(m_tdata), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_cnts", 64'({pkt_cnt, err_cnt}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_tready", 64'(s_tready), 64'd1);

        // Basic routing to ch1
        send_pkt(32'hA501_0004, 4, 32'h11);
        drain();

        // Backpressure on ch1 for 5 cycles
        saw_low = 1'b0;
        fork
            send_pkt(32'hA501_0004, 4, 32'h11);
            begin
                for (int c = 0; c < 50; c++) begin
                    @(posedge clk); #1;
                    if (m_tvalid[1]) break;
                end
                m_tready[1] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!s_tready) saw_low = 1'b1;
                end
                @(posedge clk); #1;
                m_tready[1] = 1'b1;
            end
        join
        check_eq("stall_s_tready_low", 64'(saw_low), 64'd1);
        drain();

        // Bad sync, bad dest, then a good packet on ch3
        send_pkt(32'h5A00_0002, 2, 32'h100);
        send_pkt(32'hA507_0002, 2, 32'h200);
        drain();
        send_pkt(32'hA503_0003, 3, 32'h300);
        drain();
        // Header carrying tlast itself
        send_pkt(32'hA500_0001, 0, 32'h0);
        drain();

        // Length mismatches on ch2 (short and long)
        send_pkt(32'hA502_0003, 2, 32'h400);
        drain();
        send_pkt(32'hA502_0003, 5, 32'h500);
        drain();
        // Exact length on ch0
        send_pkt(32'hA500_0002, 2, 32'h600);
        drain();

        // Reset mid-packet
        sb[1].push_back({1'b0, 32'h11});
        sb[1].push_back({1'b0, 32'h22});
        send_beat(32'hA501_0004, 1'b0);
        send_beat(32'h11, 1'b0);
        send_beat(32'h22, 1'b0);
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_tready", 64'(s_tready), 64'd0);
        check_eq("midrst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_cnts", 64'({pkt_cnt, err_cnt}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_pkt = 0;
        exp_err = 1;
        send_beat(32'h33, 1'b0);
        send_beat(32'h44, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain();

        // route_en low: everything accepted and dropped silently
        route_en = 1'b0;
        stall_cnt = 0;
        send_pkt(32'hA501_0004, 4, 32'h700);
        check_eq("rten_off_stalls", 64'(stall_cnt), 64'd0);
        drain();
        route_en = 1'b1;
        send_pkt(32'hA502_0001, 1, 32'h800);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
